// File: rtl/signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : signed_divider
// Description : Sequential two's-complement divider built on an unsigned
//               restoring-division core. Operands are converted to unsigned
//               magnitudes on acceptance. One quotient bit is then produced
//               per clock. Result signs are applied in a final fix-up cycle.
//               Quotient truncates toward zero. The remainder takes the sign
//               of the dividend.
// Ports       :
//   clk          in   single clock, all state updates on rising edge
//   reset        in   synchronous active-high reset
//   start        in   request a division (accepted only when idle)
//   dividend     in   WIDTH-bit two's-complement dividend
//   divisor      in   WIDTH-bit two's-complement divisor
//   busy         out  high while a division is in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  WIDTH-bit two's-complement quotient
//   remainder    out  WIDTH-bit two's-complement remainder
//   div_by_zero  out  set together with done when the divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module signed_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // The counter is one bit wider than log2 so it can hold WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_INIT   = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   count_q,       count_d;
    logic [WIDTH-1:0]   dvsr_q,        dvsr_d;      // divisor magnitude
    logic [WIDTH-1:0]   rem_q,         rem_d;       // partial remainder
    logic [WIDTH-1:0]   quo_q,         quo_d;       // dividend in, quotient out
    logic               neg_a_q,       neg_a_d;     // dividend sign
    logic               neg_b_q,       neg_b_d;     // divisor sign
    logic               dbz_q,         dbz_d;       // divisor was zero
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic [WIDTH-1:0]   quotient_q,    quotient_d;
    logic [WIDTH-1:0]   remainder_q,   remainder_d;
    logic               div_by_zero_q, div_by_zero_d;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
        return ~v + C_ONE;
    endfunction

    // The most negative value negates to itself. Its bit pattern read as
    // unsigned is exactly 2^(WIDTH-1), so the magnitude needs no extra bit.
    logic [WIDTH-1:0] w_dividend_mag;
    logic [WIDTH-1:0] w_divisor_mag;

    assign w_dividend_mag = dividend[WIDTH-1] ? neg2(dividend) : dividend;
    assign w_divisor_mag  = divisor[WIDTH-1]  ? neg2(divisor)  : divisor;

    // One restoring step: bring the next dividend bit (MSB of quo_q) into
    // the partial remainder, then trial-subtract. No borrow means it fits.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, dvsr_q};
    assign w_fits  = ~w_trial[WIDTH];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        dvsr_d        = dvsr_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        neg_a_d       = neg_a_q;
        neg_b_d       = neg_b_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvsr_d  = w_divisor_mag;
                    quo_d   = w_dividend_mag;
                    rem_d   = '0;
                    neg_a_d = dividend[WIDTH-1];
                    neg_b_d = divisor[WIDTH-1];
                    dbz_d   = (divisor == '0);
                    count_d = C_CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // Counter runs WIDTH -> 0. The zero cycle only hands over to
                // the fix-up state, so the counter never wraps.
                if (count_q != '0) begin
                    rem_d   = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    quo_d   = {quo_q[WIDTH-2:0], w_fits};
                    count_d = count_q - C_CNT_ONE;
                end else begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // With a zero divisor every trial subtract succeeds. That
                // leaves quo all ones and rem = |dividend|. Forcing the
                // quotient keeps it all ones whatever the dividend's sign.
                // The sign fix-up on rem turns it back into the dividend.
                if (dbz_q) begin
                    quotient_d = '1;
                end else if (neg_a_q ^ neg_b_q) begin
                    quotient_d = neg2(quo_q);
                end else begin
                    quotient_d = quo_q;
                end
                remainder_d   = neg_a_q ? neg2(rem_q) : rem_q;
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            dvsr_q        <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            dvsr_q        <= dvsr_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            neg_a_q       <= neg_a_d;
            neg_b_q       <= neg_b_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_divider
// Description : Directed self-checking bench for signed_divider at WIDTH=16.
//               Expected quotients, remainders and latencies are computed
//               by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    signed_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one division and checks latency, busy length and results.
    // The call starts and ends at 1 time unit after a rising edge.
    // pulse_at > 0 pulses start with 1/1 operands at that cycle of the run.
    // keep_start leaves start asserted for the whole run and on return.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input int pulse_at, input bit keep_start,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic edz, input string tag);
        int lat;
        int busy_cnt;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;           // acceptance edge E0
        if (!keep_start) start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        for (int n = 1; n <= 40; n++) begin
            if (pulse_at != 0 && n == pulse_at) begin
                start    = 1'b1;
                dividend = 16'd1;
                divisor  = 16'd1;
            end
            if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, lat, 18);
        chk({tag, " busy_cycles"}, busy_cnt, 18);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, edz);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset dbz", div_by_zero, 0);
        reset = 1'b0;

        // Basic sign combinations.
        run_div(16'd100,   16'd7,    0, 1'b0, 16'h000E, 16'h0002, 1'b0, "100/7");
        run_div(16'hFF9C,  16'd7,    0, 1'b0, 16'hFFF2, 16'hFFFE, 1'b0, "-100/7");
        run_div(16'd100,   16'hFFF9, 0, 1'b0, 16'hFFF2, 16'h0002, 1'b0, "100/-7");
        run_div(16'hFF9C,  16'hFFF9, 0, 1'b0, 16'h000E, 16'hFFFE, 1'b0, "-100/-7");

        // Divide by zero, positive and negative dividend.
        run_div(16'd1234,  16'd0,    0, 1'b0, 16'hFFFF, 16'h04D2, 1'b0 | 1'b1, "1234/0");
        run_div(16'hFF9C,  16'd0,    0, 1'b0, 16'hFFFF, 16'hFF9C, 1'b1, "-100/0");

        // Most negative value and boundary magnitudes.
        run_div(16'h8000,  16'hFFFF, 0, 1'b0, 16'h8000, 16'h0000, 1'b0, "-32768/-1");
        run_div(16'h8000,  16'd1,    0, 1'b0, 16'h8000, 16'h0000, 1'b0, "-32768/1");
        run_div(16'h8000,  16'd3,    0, 1'b0, 16'hD556, 16'hFFFE, 1'b0, "-32768/3");
        run_div(16'd7,     16'h7FFF, 0, 1'b0, 16'h0000, 16'h0007, 1'b0, "7/32767");

        // Results hold while idle.
        repeat (5) @(posedge clk);
        #1;
        chk("hold quotient", quotient, 16'h0000);
        chk("hold remainder", remainder, 16'h0007);
        chk("hold done", done, 0);

        // Reset aborts a running division.
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort remainder", remainder, 0);
        reset = 1'b0;
        // An early done from the aborted run would show up as a short latency.
        run_div(16'd9, 16'd3, 0, 1'b0, 16'h0003, 16'h0000, 1'b0, "9/3 after abort");

        // Start pulsed mid-run is ignored.
        run_div(16'd200, 16'd9, 5, 1'b0, 16'd22, 16'd2, 1'b0, "200/9 with pulse");

        // Start held high: the run ignores it. The next division is then
        // accepted in the cycle where done is high.
        run_div(16'd100, 16'd7, 0, 1'b1, 16'h000E, 16'h0002, 1'b0, "held first");
        chk("held done high at return", done, 1);
        run_div(16'hFF9C, 16'hFFF9, 0, 1'b0, 16'h000E, 16'hFFFE, 1'b0, "back-to-back");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
